// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC constants and dot-product sequencer state enum
package mac_pkg;

  localparam int MAC_IN_W  = 8;
  localparam int MAC_ACC_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4
  } mac_seq_state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - sequences one dot-product job into mac_unit and captures the result
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int MAC_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [MAC_ACC_W-1:0] bias,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [MAC_IN_W-1:0]  in_x,
  input  logic signed [MAC_IN_W-1:0]  in_y,
  input  logic                        in_last,
  output logic                        mac_en,
  output logic                        mac_acc_load,
  output logic signed [MAC_ACC_W-1:0] mac_z,
  output logic signed [MAC_IN_W-1:0]  mac_x,
  output logic signed [MAC_IN_W-1:0]  mac_y,
  input  logic signed [MAC_ACC_W-1:0] mac_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [MAC_ACC_W-1:0] out_data,
  output logic [LEN_W-1:0]            out_count,
  output logic                        out_trunc
);

  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  mac_seq_state_t              state, state_next;
  logic signed [MAC_ACC_W-1:0] bias_q;
  logic [LEN_W-1:0]            count;
  logic [DRAIN_W-1:0]          drain_cnt;
  logic                        trunc_q;
  logic                        hs;
  logic                        at_max;
  logic                        drain_done;

  // A pair is accepted only in STREAM, where in_ready is the state decode
  assign hs         = in_valid && in_ready;
  assign at_max     = (count == LEN_W'(VEC_LEN - 1));
  assign drain_done = (drain_cnt == DRAIN_W'(MAC_LAT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and combinational MAC drive; bubbles feed zero operands so the accumulator holds
  always_comb begin
    state_next   = state;
    busy         = 1'b1;
    in_ready     = 1'b0;
    mac_en       = 1'b0;
    mac_acc_load = 1'b0;
    mac_z        = '0;
    mac_x        = '0;
    mac_y        = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        mac_en       = 1'b1;
        mac_acc_load = 1'b1;
        mac_z        = bias_q;
        state_next   = S_STREAM;
      end
      S_STREAM: begin
        in_ready = 1'b1;
        mac_en   = 1'b1;
        if (in_valid) begin
          mac_x = in_x;
          mac_y = in_y;
          if (in_last || at_max) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        mac_en = 1'b1;
        if (drain_done) state_next = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Job bookkeeping and the registered result slot
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q    <= '0;
      count     <= '0;
      drain_cnt <= '0;
      trunc_q   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bias_q    <= bias;
            count     <= '0;
            drain_cnt <= '0;
            trunc_q   <= 1'b0;
          end
        end
        S_STREAM: begin
          if (hs) begin
            count <= count + 1'b1;
            if (at_max && !in_last) trunc_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_done) begin
            out_data  <= mac_result;
            out_count <= count;
            out_trunc <= trunc_q;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - directed self-checking bench for mac_dot_seq
module tb_mac_dot_seq;

  localparam int VEC_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int LAT     = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [31:0] bias;
  logic busy;
  logic in_valid, in_ready, in_last;
  logic signed [7:0] in_x, in_y;
  logic mac_en, mac_acc_load;
  logic signed [31:0] mac_z;
  logic signed [7:0] mac_x, mac_y;
  logic signed [31:0] mac_result;
  logic out_valid, out_ready, out_trunc;
  logic signed [31:0] out_data;
  logic [LEN_W-1:0] out_count;

  mac_dot_seq #(.VEC_LEN(VEC_LEN), .LEN_W(LEN_W), .MAC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .mac_en(mac_en), .mac_acc_load(mac_acc_load), .mac_z(mac_z), .mac_x(mac_x), .mac_y(mac_y),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: one product stage then the accumulator, giving LAT=2 from operands to Result
  logic               ld_p;
  logic signed [31:0] z_p, pr_p, acc_m;
  always @(posedge clk) begin
    if (rst) begin
      ld_p <= 1'b0; z_p <= 0; pr_p <= 0; acc_m <= 0;
    end else if (mac_en) begin
      ld_p  <= mac_acc_load;
      z_p   <= mac_z;
      pr_p  <= mac_x * mac_y;
      acc_m <= ld_p ? z_p : acc_m + pr_p;
    end
  end
  assign mac_result = acc_m;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Job expectations produced by the bench model
  logic               exp_active = 1'b0;
  logic signed [31:0] exp_data;
  int                 exp_count;
  logic               exp_trunc;
  int                 exp_cyc;

  // Compare process: every cycle the result slot is valid it must match the model
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      if (!exp_active) chk("unexpected_out_valid", 1, 0);
      else begin
        chk("out_data", out_data, exp_data);
        chk("out_count", 32'(out_count), exp_count);
        chk("out_trunc", 32'(out_trunc), 32'(exp_trunc));
        if (!prev_valid) chk("out_valid_cycle", cyc, exp_cyc);
      end
    end
    prev_valid = out_valid;
  end

  int jx[VEC_LEN], jy[VEC_LEN], jb[VEC_LEN];

  task automatic clear_job();
    for (int i = 0; i < VEC_LEN; i++) begin jx[i] = 0; jy[i] = 0; jb[i] = 0; end
  endtask

  task automatic run_job(input int b, input int n, input bit use_last, input bit hold, input int lit);
    logic signed [31:0] sum;
    int bub;
    sum = b; bub = 0;
    for (int i = 0; i < n; i++) begin
      sum = sum + jx[i] * jy[i];
      bub += jb[i];
    end
    chk("model_pin", sum, lit);
    exp_data   = sum;
    exp_count  = n;
    exp_trunc  = (n == VEC_LEN) && !use_last;
    exp_cyc    = cyc + n + 2 + LAT + bub;
    exp_active = 1'b1;
    start = 1'b1; bias = b;
    @(posedge clk); #1;
    start = 1'b0; bias = 32'sd12345;
    chk("load_acc_load", 32'(mac_acc_load), 1);
    chk("load_mac_z", mac_z, b);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < jb[i]; k++) begin
        in_valid = 1'b0; in_last = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_x = 8'(jx[i]); in_y = 8'(jy[i]);
      in_last = use_last && (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_x = 0; in_y = 0;
    chk("in_ready_after_stream", 32'(in_ready), 0);
    chk("busy_in_drain", 32'(busy), 1);
    for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
    chk("out_valid_timeout", 32'(out_valid), 1);
    chk("out_data_literal", out_data, lit);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        start = 1'(k % 2 == 0); bias = 32'sd999;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_data", out_data, lit);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_active = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_out_valid", 32'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias = 0; in_valid = 1'b0; in_last = 1'b0;
    in_x = 0; in_y = 0; out_ready = 1'b0;
    clear_job();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mac_en", 32'(mac_en), 0);
    chk("rst_acc_load", 32'(mac_acc_load), 0);
    chk("rst_mac_z", mac_z, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_trunc", 32'(out_trunc), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    clear_job(); jx[0] = 10; jy[0] = 3;
    run_job(50, 1, 1'b1, 1'b0, 80);

    clear_job(); jx[0] = -5; jy[0] = 4;
    run_job(-20, 1, 1'b1, 1'b0, -40);
    clear_job(); jx[0] = 7; jy[0] = -6;
    run_job(0, 1, 1'b1, 1'b0, -42);

    clear_job();
    jx[0] = 7; jy[0] = -6; jx[1] = 2; jy[1] = 5; jb[1] = 1; jx[2] = -1; jy[2] = -1; jb[2] = 1;
    run_job(0, 3, 1'b1, 1'b0, -31);

    clear_job();
    for (int i = 0; i < VEC_LEN; i++) begin jx[i] = 1; jy[i] = 1; end
    run_job(0, VEC_LEN, 1'b0, 1'b0, 16);

    clear_job(); jx[0] = 4; jy[0] = 4;
    run_job(3, 1, 1'b1, 1'b1, 19);

    // Reset in the middle of STREAM after two accepted pairs
    start = 1'b1; bias = 100;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = 3; in_y = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_x = 0; in_y = 0;
    chk("pre_rst_in_ready", 32'(in_ready), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_mac_en", 32'(mac_en), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_count", 32'(out_count), 0);
    chk("midrst_out_data", out_data, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(out_valid), 0);

    clear_job(); jx[0] = 2; jy[0] = 2;
    run_job(5, 1, 1'b1, 1'b0, 9);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
